// File: rtl/mips_wb_pkg.sv
// rtl/mips_wb_pkg.sv - shared writeback types and widths
package mips_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small FIFO of writeback requests
module wb_fifo
    import mips_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  wb_req_t                push_req,
    input  logic                   pop,
    output wb_req_t                head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is not reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_req;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - register-file write port arbiter with pending scoreboard
module wb_write_arbiter
    import mips_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  llu_valid,
    output logic                  llu_ready,
    input  logic [REG_ADDR_W-1:0] llu_reg,
    input  logic [DATA_W-1:0]     llu_data,
    input  logic                  reserve_valid,
    input  logic [REG_ADDR_W-1:0] reserve_reg,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    output logic                  stall,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0]     write_data
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_req_t              llu_req;
    wb_req_t              fifo_head;
    wb_req_t              commit_req;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic                 commit;
    logic [NUM_REGS-1:0]  pending;
    logic [NUM_REGS-1:0]  pending_next;

    wb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_req (llu_req),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Ready comes from the registered count, so a pop while full never opens the door that cycle.
    assign llu_ready = rst_n && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign fifo_push = llu_valid && llu_ready && !fifo_full;
    assign fifo_pop  = !alu_valid && !fifo_empty;
    assign stall     = pending[rs] | pending[rt];

    always_comb begin
        llu_req.rd   = llu_reg;
        llu_req.data = llu_data;
        commit       = alu_valid || !fifo_empty;
        if (alu_valid) begin
            commit_req.rd   = alu_reg;
            commit_req.data = alu_data;
        end else begin
            commit_req = fifo_head;
        end
    end

    // A reservation issued on the clearing edge is a new outstanding op, so set follows clear.
    always_comb begin
        pending_next = pending;
        if (fifo_pop) begin
            pending_next[fifo_head.rd] = 1'b0;
        end
        if (reserve_valid) begin
            pending_next[reserve_reg] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            pending    <= '0;
        end else begin
            pending   <= pending_next;
            reg_write <= commit && (commit_req.rd != '0);
            if (commit) begin
                write_reg  <= commit_req.rd;
                write_data <= commit_req.data;
            end
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - randomized and directed bench against a queue-based reference model
module tb_wb_write_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        llu_valid;
    logic        llu_ready;
    logic [4:0]  llu_reg;
    logic [31:0] llu_data;
    logic        reserve_valid;
    logic [4:0]  reserve_reg;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        stall;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;

    int checks   = 0;
    int failures = 0;

    logic [4:0]  q_rd[$];
    logic [31:0] q_data[$];
    bit          pend[32];
    logic        exp_rw;
    logic [4:0]  exp_wr;
    logic [31:0] exp_wd;
    bit          acc;

    wb_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid     (alu_valid),
        .alu_reg       (alu_reg),
        .alu_data      (alu_data),
        .llu_valid     (llu_valid),
        .llu_ready     (llu_ready),
        .llu_reg       (llu_reg),
        .llu_data      (llu_data),
        .reserve_valid (reserve_valid),
        .reserve_reg   (reserve_reg),
        .rs            (rs),
        .rt            (rt),
        .stall         (stall),
        .reg_write     (reg_write),
        .write_reg     (write_reg),
        .write_data    (write_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alu_valid     = 1'b0;
        llu_valid     = 1'b0;
        reserve_valid = 1'b0;
    endtask

    // Advance the model by one cycle from the current inputs, clock the DUT, then compare.
    task automatic step();
        logic [4:0]  r;
        logic [31:0] d;
        if (!rst_n) begin
            q_rd.delete();
            q_data.delete();
            pend   = '{default: 1'b0};
            exp_rw = 1'b0;
            exp_wr = '0;
            exp_wd = '0;
            acc    = 1'b0;
        end else begin
            acc    = llu_valid && (q_rd.size() < DEPTH);
            exp_rw = 1'b0;
            if (alu_valid) begin
                exp_rw = (alu_reg != 0);
                exp_wr = alu_reg;
                exp_wd = alu_data;
            end else if (q_rd.size() > 0) begin
                r = q_rd.pop_front();
                d = q_data.pop_front();
                exp_rw  = (r != 0);
                exp_wr  = r;
                exp_wd  = d;
                pend[r] = 1'b0;
            end
            if (acc) begin
                q_rd.push_back(llu_reg);
                q_data.push_back(llu_data);
            end
            if (reserve_valid && reserve_reg != 0) begin
                pend[reserve_reg] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("reg_write", reg_write, exp_rw);
        if (exp_rw || !rst_n) begin
            chk("write_reg", write_reg, exp_wr);
            chk("write_data", write_data, exp_wd);
        end
        chk("llu_ready", llu_ready, rst_n && (q_rd.size() < DEPTH));
        chk("stall", stall, pend[rs] | pend[rt]);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        idle();
        alu_reg = 5'd3; alu_data = 32'h55; llu_reg = 5'd4; llu_data = 32'h66;
        reserve_reg = 5'd0; rs = 5'd0; rt = 5'd0;

        // reset held with traffic offered
        alu_valid = 1'b1;
        llu_valid = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        idle();
        step();

        // ALU path, including register 0
        alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h1234;
        step();
        alu_reg = 5'd0;
        step();
        idle();
        step();

        // ALU priority over three buffered long-latency results
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_reg = 5'(1 + i); alu_data = 32'h100 + i;
            llu_valid = (i < 3); llu_reg = 5'(8 + i); llu_data = 32'h800 + i;
            step();
        end
        idle();
        for (int i = 0; i < 5; i++) step();

        // fill while ALU is busy; fifth offer held until space frees
        k = 0;
        for (int i = 0; i < 12 && k < 5; i++) begin
            alu_valid = (i < 6); alu_reg = 5'd20; alu_data = 32'(i);
            llu_valid = 1'b1; llu_reg = 5'(11 + k); llu_data = 32'hA0 + k;
            step();
            if (acc) k++;
        end
        idle();
        for (int i = 0; i < 7; i++) step();

        // scoreboard: reserve 7, complete it, then re-reserve on the clearing edge
        rs = 5'd7; rt = 5'd0;
        reserve_valid = 1'b1; reserve_reg = 5'd7;
        step();
        idle();
        step();
        step();
        llu_valid = 1'b1; llu_reg = 5'd7; llu_data = 32'hBEEF;
        step();
        idle();
        step();
        step();
        reserve_valid = 1'b1; reserve_reg = 5'd7;
        step();
        idle();
        llu_valid = 1'b1; llu_reg = 5'd7; llu_data = 32'hCAFE;
        step();
        idle();
        reserve_valid = 1'b1; reserve_reg = 5'd7;
        step();
        idle();
        step();
        step();

        // mid-operation reset with two buffered entries and three reservations
        rt = 5'd9;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'(i);
            reserve_valid = 1'b1; reserve_reg = 5'(7 + i);
            llu_valid = (i < 2); llu_reg = 5'(7 + i); llu_data = 32'hD0 + i;
            step();
        end
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst_n         = ($urandom_range(0, 99) != 0);
            alu_valid     = ($urandom_range(0, 2) == 0);
            alu_reg       = 5'($urandom_range(0, 7));
            alu_data      = $urandom;
            llu_valid     = $urandom_range(0, 1);
            llu_reg       = 5'($urandom_range(0, 7));
            llu_data      = $urandom;
            reserve_valid = ($urandom_range(0, 3) == 0);
            reserve_reg   = 5'($urandom_range(0, 7));
            rs            = 5'($urandom_range(0, 7));
            rt            = 5'($urandom_range(0, 7));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Writeback-side driver of the register file's single write port. Merges single-cycle ALU results with results from the long-latency unit (loads, mult/div) through a small FIFO. Presents one registered write per cycle to the register file (`reg_write`, `write_reg`, `write_data`). Also keeps a per-register pending scoreboard so the decode stage can stall on outstanding long-latency destinations.

## Interface
- `FIFO_DEPTH`, 4: long-latency result buffer entries; power of two, ≥2.
- `clk`  in  1  rising-edge clock, shared with the register file.
- `rst_n`  in  1  synchronous, active-low reset.
- `alu_valid`  in  1  ALU result present this cycle; no backpressure.
- `alu_reg`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `llu_valid`  in  1  long-latency result offered.
- `llu_ready`  out  1  FIFO can accept; transfer when `llu_valid && llu_ready`.
- `llu_reg`  in  5  long-latency destination.
- `llu_data`  in  32  long-latency result.
- `reserve_valid`  in  1  decode issued a long-latency op.
- `reserve_reg`  in  5  its destination.
- `rs`, `rt`  in  5 each  decode source registers.
- `stall`  out  1  `pending[rs] | pending[rt]`.
- `reg_write`  out  1  register-file write enable.
- `write_reg`  out  5  register-file write address.
- `write_data`  out  32  register-file write data.

## Operation
- Reset (`rst_n` low at a posedge) values:
  - `reg_write`, `write_reg`, `write_data` = 0.
  - FIFO empty; pending mask = 0.
  - `llu_ready` forced 0 while `rst_n` low.
  - Reset mid-operation discards FIFO contents and all reservations.
- Commit selection each cycle:
  - If `alu_valid`, the ALU result commits.
  - Else, if the FIFO is non-empty, its head pops and commits.
  - Else nothing commits.
  - The ALU always has priority; FIFO drain can starve under back-to-back ALU traffic, and `llu_ready` then stays low when full.
- A committed request is loaded into the output registers: `reg_write` = 1, plus address and data.
- A commit to register 0 still pops/consumes the request, but drives `reg_write` = 0.
- With no commit, `reg_write` = 0; `write_reg`/`write_data` hold their previous values.
- FIFO acceptance:
  - `llu_ready = rst_n && (count < FIFO_DEPTH)`, computed from the registered count.
  - When full, a same-cycle pop does not raise `llu_ready`.
  - An enqueue and a pop in the same cycle leave the count unchanged; FIFO order is preserved.
- Pointers are `log2(FIFO_DEPTH)` bits and wrap naturally; count is `log2(FIFO_DEPTH)+1` bits.
- Scoreboard (32-bit mask):
  - `reserve_valid` sets `pending[reserve_reg]`.
  - A commit of an FIFO entry clears `pending[write_reg of that entry]`.
  - Set and clear of the same register in the same cycle: set wins (a new reservation is outstanding).
  - Bit 0 is never set.
  - ALU commits do not clear pending bits.
- `stall` is combinational from the registered mask; a bit cleared at edge N is visible as not-pending in cycle N+1.

## Timing
- ALU result presented in cycle N → `reg_write` high during cycle N+1; the register file captures it at the end of N+1.
- Long-latency handshake at edge N into an empty FIFO with no ALU traffic → popped in cycle N+1 → `reg_write` high in cycle N+2.
- Throughput: one register-file write per cycle maximum.
- The register file reads at its clock edge, so decode must keep `stall` asserted until the pending bit clears. Forwarding of the in-flight output register is not provided by this block.

## Structure
- Shared package `mips_wb_pkg`:
  - `REG_ADDR_W` = 5, `DATA_W` = 32.
  - Struct `wb_req_t` {`rd`, `data`}.
- Sub-module `wb_fifo`: parameterized `wb_req_t` FIFO with push/pop/full/empty/count.
- Arbitration, output registers and scoreboard live in the top module.

## Test plan
- Reset: hold `rst_n` low 2 cycles while driving `alu_valid`=1 and `llu_valid`=1 → all outputs 0, `llu_ready`=0, `stall`=0; the first cycle after release has `reg_write`=0.
- ALU path: `alu_valid`, reg 5, data 0x1234 in cycle N → cycle N+1 `reg_write`=1, `write_reg`=5, `write_data`=0x1234. Same request to reg 0 → `reg_write`=0.
- Priority/order: 3 long-latency results (regs 8,9,10) accepted while `alu_valid` is high 4 cycles → writes appear ALU×4, then 8, 9, 10 in order.
- Full: 4 accepted while ALU is busy → `llu_ready`=0 from the next cycle; a 5th offer is held and not lost; it is accepted in the cycle after the first drain.
- Scoreboard: reserve reg 7, `rs`=7 → `stall`=1 from the next cycle until one cycle after the FIFO commit of reg 7. A new reserve of 7 on the clearing edge → `stall` stays 1.
- Mid-operation reset with 2 FIFO entries and 3 pending bits → after release, FIFO empty, no writes emitted, mask 0.
